// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU round-robin arbiter: opcode encodings,
// flag bit positions and the FSM state type.
package alu_arb_pkg;

  localparam int OPW  = 3;
  localparam int FLGW = 7;

  // The arbiter never decodes these; they document the ALU it fronts.
  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_SHL = 3'd5;
  localparam logic [OPW-1:0] OP_SHR = 3'd6;
  localparam logic [OPW-1:0] OP_CMP = 3'd7;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_NEG   = 3;
  localparam int FLG_EQ    = 4;
  localparam int FLG_BGT   = 5;
  localparam int FLG_COUT  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, wrapping around. The priority pointer lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      // Offset NREQ revisits last_grant itself, so a lone requester still wins.
      for (int off = 1; off <= NREQ; off++) begin
        idx = (int'(last_grant) + off) % NREQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one external combinational ALU among NREQ requesters with
// round-robin arbitration. Optional grant counters: define ALU_ARB_STATS_EN.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int OPW  = 3,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [OPW-1:0]    alu_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic              alu_cin,
  input  logic [DW-1:0]     alu_result,
  input  logic [6:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [DW-1:0]     rsp_result,
  output logic [6:0]        rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [NREQ*16-1:0] stat_grants
`endif
);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [IW-1:0]   id_q, id_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic            alu_cin_q, alu_cin_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_result_q, rsp_result_d;
  logic [6:0]      rsp_flags_q, rsp_flags_d;

  logic            grant_en;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [OPW-1:0]  sel_op;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            sel_cin;

  // A new op may start while idle, or while the pending response is being
  // consumed this very cycle, which gives one op every two cycles.
  assign grant_en = !rst && ((state_q == ST_IDLE) ||
                             ((state_q == ST_RESP) && rsp_ready));

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .enable     (grant_en),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[i*OPW +: OPW];
        sel_a   = req_a[i*DW +: DW];
        sel_b   = req_b[i*DW +: DW];
        sel_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      alu_op_d     = sel_op;
      alu_a_d      = sel_a;
      alu_b_d      = sel_b;
      alu_cin_d    = sel_cin;
      id_d         = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  // Reset discards any in-flight op and pending response without a reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NREQ - 1);
      id_q         <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_cnt_q [NREQ];

  // Clear beats increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || stat_clr) begin
        stat_cnt_q[i] <= '0;
      end else if (grant[i]) begin
        stat_cnt_q[i] <= satInc16(stat_cnt_q[i]);
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_grants[i*16 +: 16] = stat_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with a stub ALU and a transaction
// level reference model; also covers the grant counters under ALU_ARB_STATS_EN.
module tb_alu_rr_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int OPW  = 3;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic [OPW-1:0]       alu_op;
  logic [DW-1:0]        alu_a;
  logic [DW-1:0]        alu_b;
  logic                 alu_cin;
  logic [DW-1:0]        alu_result;
  logic [6:0]           alu_flags;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [DW-1:0]        rsp_result;
  logic [6:0]           rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic                 stat_clr;
  logic [NREQ*16-1:0]   stat_grants;
  int                   statModel [NREQ];
`endif

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  // Stub ALU: returns {flags, result}.
  function automatic logic [38:0] stubAlu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] wide;
    logic [31:0] res;
    logic        v;
    wide = '0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        v    = (a[31] == b[31]) && (wide[31] != a[31]);
      end
      OP_SUB, OP_CMP: begin
        wide = {1'b0, a} - {1'b0, b};
        v    = (a[31] != b[31]) && (wide[31] != a[31]);
      end
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_SHL:  wide = {1'b0, a} << b[4:0];
      OP_SHR:  wide = {1'b0, a >> b[4:0]};
      default: wide = '0;
    endcase
    res = wide[31:0];
    return {wide[32], (a > b), (a == b), res[31], v, wide[32], (res == 32'd0), res};
  endfunction

  always_comb {alu_flags, alu_result} = stubAlu(alu_op, alu_a, alu_b, alu_cin);

  // Reference model: the op accepted last cycle, the response awaiting
  // consumption, and the requester most recently served.
  int          checks;
  int          errors;
  int          lastGrant;
  bit          inFlight;
  bit          rspPend;
  logic [1:0]  flightId, pendId;
  logic [2:0]  flightOp;
  logic [31:0] flightA, flightB, flightRes, pendRes;
  logic        flightCin;
  logic [6:0]  flightFlg, pendFlg;
  int          acceptLog[$];

  function automatic int pickNext(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy, input logic rstVal);
    rst       = rstVal;
    req_valid = valid;
    rsp_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i*OPW +: OPW] = 3'($urandom_range(0, 7));
      req_a[i*DW +: DW]    = $urandom;
      req_b[i*DW +: DW]    = $urandom;
      req_cin[i]           = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic resetModel();
    lastGrant = NREQ - 1;
    inFlight  = 1'b0;
    rspPend   = 1'b0;
  endtask

  // Called at a negedge with inputs driven; checks, then advances one clock.
  task automatic runCycle();
    int              g;
    logic [NREQ-1:0] expReady;
    #2;
    g        = -1;
    expReady = '0;
    if (!rst && !inFlight && (!rspPend || rsp_ready)) g = pickNext(req_valid, lastGrant);
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(rspPend));
    if (rspPend) begin
      checkOutput("rsp_id", 64'(rsp_id), 64'(pendId));
      checkOutput("rsp_result", 64'(rsp_result), 64'(pendRes));
      checkOutput("rsp_flags", 64'(rsp_flags), 64'(pendFlg));
    end
    if (inFlight) begin
      checkOutput("alu_op", 64'(alu_op), 64'(flightOp));
      checkOutput("alu_a", 64'(alu_a), 64'(flightA));
      checkOutput("alu_b", 64'(alu_b), 64'(flightB));
      checkOutput("alu_cin", 64'(alu_cin), 64'(flightCin));
    end
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      checkOutput("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(statModel[i]));
`endif
    @(posedge clk);
    if (rst) begin
      resetModel();
    end else begin
      if (rspPend && rsp_ready) rspPend = 1'b0;
      if (inFlight) begin
        rspPend = 1'b1;
        pendId  = flightId;
        pendRes = flightRes;
        pendFlg = flightFlg;
      end
      inFlight = (g >= 0);
      if (g >= 0) begin
        flightId  = 2'(g);
        flightOp  = req_op[g*OPW +: OPW];
        flightA   = req_a[g*DW +: DW];
        flightB   = req_b[g*DW +: DW];
        flightCin = req_cin[g];
        {flightFlg, flightRes} = stubAlu(flightOp, flightA, flightB, flightCin);
        lastGrant = g;
        acceptLog.push_back(g);
      end
    end
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      if (rst || stat_clr) statModel[i] = 0;
      else if (g == i && statModel[i] < 65535) statModel[i] = statModel[i] + 1;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetModel();
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) statModel[i] = 0;
`endif

    // Reset: first edge initialises the DUT, then reset values are checked.
    applyStimulus('1, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rsp_result", 64'(rsp_result), 64'd0);
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    checkOutput("rst_alu_op", 64'(alu_op), 64'd0);
    checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
    checkOutput("rst_alu_b", 64'(alu_b), 64'd0);
    checkOutput("rst_alu_cin", 64'(alu_cin), 64'd0);
    runCycle();

    // Single request from requester 2: 5 + 7.
    applyStimulus(4'b0100, 1'b1, 1'b0);
    req_op[2*OPW +: OPW] = OP_ADD;
    req_a[2*DW +: DW]    = 32'd5;
    req_b[2*DW +: DW]    = 32'd7;
    req_cin[2]           = 1'b0;
    runCycle();
    checkOutput("single_grant_id", 64'(acceptLog[$]), 64'd2);
    applyStimulus('0, 1'b1, 1'b0);
    runCycle();
    #2;
    checkOutput("single_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("single_rsp_id", 64'(rsp_id), 64'd2);
    checkOutput("single_rsp_result", 64'(rsp_result), 64'd12);
    runCycle();

    // Round robin from reset with every requester active.
    applyStimulus('0, 1'b1, 1'b1);
    runCycle();
    acceptLog.delete();
    for (int c = 0; c < 10; c++) begin
      applyStimulus('1, 1'b1, 1'b0);
      runCycle();
    end
    checkOutput("rr_accept_count", 64'(acceptLog.size()), 64'd5);
    for (int k = 0; k < acceptLog.size(); k++)
      checkOutput("rr_order", 64'(acceptLog[k]), 64'(k % NREQ));

    // Backpressure: response held while others keep requesting.
    for (int c = 0; c < 6; c++) begin
      applyStimulus('1, 1'b0, 1'b0);
      runCycle();
    end
    applyStimulus('1, 1'b1, 1'b0);
    #2;
    checkOutput("bp_release_grant", 64'(|req_ready), 64'd1);
    runCycle();

    // Back-to-back between two requesters.
    acceptLog.delete();
    for (int c = 0; c < 9; c++) begin
      applyStimulus(4'b1010, 1'b1, 1'b0);
      runCycle();
    end
    for (int k = 1; k < acceptLog.size(); k++)
      checkOutput("b2b_alternate", 64'(acceptLog[k] != acceptLog[k-1]), 64'd1);

    // Reset during the execute cycle discards the op.
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0, 1'b1, 1'b0);
      runCycle();
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    runCycle();
    applyStimulus('1, 1'b1, 1'b1);
    runCycle();
    applyStimulus('1, 1'b1, 1'b0);
    #2;
    checkOutput("midop_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midop_first_grant", 64'(req_ready), 64'b0001);
    runCycle();

`ifdef ALU_ARB_STATS_EN
    // Three grants to requester 1, then clear.
    applyStimulus('0, 1'b1, 1'b1);
    runCycle();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0);
      runCycle();
    end
    checkOutput("stat_three", 64'(stat_grants[16 +: 16]), 64'd3);
    applyStimulus('0, 1'b1, 1'b0);
    stat_clr = 1'b1;
    runCycle();
    stat_clr = 1'b0;
    checkOutput("stat_cleared", 64'(stat_grants[16 +: 16]), 64'd0);
`endif

    // Random traffic with random backpressure and occasional reset.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 99) == 0));
`ifdef ALU_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 49) == 0);
`endif
      runCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
